// File: rtl/pc_fetch_if.sv
// Fetch unit bus bundle: redirect/hold controls, memory request and
// response channels, and the downstream instruction channel.
interface pc_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              jmp_en_i;
  logic [ADDR_W-1:0] jmp_addr_i;
  logic              hold_i;
  logic              req_valid_o;
  logic              req_ready_i;
  logic [ADDR_W-1:0] req_addr_o;
  logic              rsp_valid_i;
  logic [INST_W-1:0] rsp_data_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;

  modport master (
    input  jmp_en_i,
    input  jmp_addr_i,
    input  hold_i,
    output req_valid_o,
    input  req_ready_i,
    output req_addr_o,
    input  rsp_valid_i,
    input  rsp_data_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o,
    output inst_pc_o
  );

  modport slave (
    output jmp_en_i,
    output jmp_addr_i,
    output hold_i,
    input  req_valid_o,
    output req_ready_i,
    input  req_addr_o,
    output rsp_valid_i,
    output rsp_data_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o,
    input  inst_pc_o
  );
endinterface

// File: rtl/pc_fetch.sv
// Fetch PC generator: issues sequential fetches, queues in-order
// responses with their PC, and redirects/flushes on jump.
// Ports: clk, rst (async, active-high), bus (pc_fetch_if.master).
// Optional macro JTAG_RST_EN adds jtag_rst_en_i, a synchronous soft
// reset that redirects to RST_ADDR with priority over jumps.
module pc_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0,
  parameter int                STEP     = 4,
  parameter int                DEPTH    = 4
) (
  input logic        clk,
  input logic        rst,
`ifdef JTAG_RST_EN
  input logic        jtag_rst_en_i,
`endif
  pc_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [INST_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic [CW:0]       in_use;
  logic              req_valid;
  logic              req_fire;
  logic              drop;
  logic              push;
  logic              inst_valid;
  logic              pop;

  always_comb begin
    flush    = bus.jmp_en_i;
    flush_pc = bus.jmp_addr_i;
`ifdef JTAG_RST_EN
    if (jtag_rst_en_i) begin
      flush    = 1'b1;
      flush_pc = RST_ADDR;
    end
`endif
  end

  // Slots are reserved at issue time, so a push never finds the
  // queue full.
  assign in_use     = {1'b0, outstanding} + {1'b0, count};
  assign req_valid  = !rst && !flush && !bus.hold_i &&
                      (in_use < (CW+1)'(DEPTH));
  assign req_fire   = req_valid && bus.req_ready_i;
  assign drop       = bus.rsp_valid_i && (discard != '0);
  assign push       = bus.rsp_valid_i && !drop && !flush;
  assign inst_valid = (count != '0) && !flush;
  assign pop        = inst_valid && bus.inst_ready_i;

  assign bus.req_valid_o  = req_valid;
  assign bus.req_addr_o   = fetch_pc;
  assign bus.inst_valid_o = inst_valid;
  assign bus.inst_o       = data_q[rd_ptr];
  assign bus.inst_pc_o    = (count == '0) ? rsp_pc : pc_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RST_ADDR;
    end else begin
      unique case (1'b1)
        flush:    fetch_pc <= flush_pc;
        req_fire: fetch_pc <= fetch_pc + STEP_A;
        default:  fetch_pc <= fetch_pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pc <= RST_ADDR;
    end else begin
      unique case (1'b1)
        flush:   rsp_pc <= flush_pc;
        push:    rsp_pc <= rsp_pc + STEP_A;
        default: rsp_pc <= rsp_pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire)
                     - CW'(bus.rsp_valid_i);
    end
  end

  // Every request still in flight at a redirect belongs to the old
  // stream; one answered in the redirect cycle is dropped directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= '0;
    end else if (flush) begin
      discard <= outstanding - CW'(bus.rsp_valid_i);
    end else if (drop) begin
      discard <= discard - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= bus.rsp_data_i;
      pc_q[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: queue-based reference model with random
// stimulus, directed sequences and an 8-bit wrap-around vector table.
`timescale 1ns/1ps
module tb_pc_fetch;
  localparam int          AW     = 32;
  localparam int          IW     = 32;
  localparam int          DEPTH  = 4;
  localparam int          STEP   = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_if #(.ADDR_W(AW), .INST_W(IW)) bus ();
  pc_fetch_if #(.ADDR_W(8), .INST_W(IW)) bus8 ();

  logic jtag = 1'b0;

  pc_fetch #(
    .ADDR_W(AW), .INST_W(IW), .RST_ADDR(RST_PC),
    .STEP(STEP), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef JTAG_RST_EN
    .jtag_rst_en_i(jtag),
`endif
    .bus(bus)
  );

  pc_fetch #(
    .ADDR_W(8), .INST_W(IW), .RST_ADDR(8'hF8),
    .STEP(4), .DEPTH(4)
  ) dut8 (
    .clk(clk),
    .rst(rst),
`ifdef JTAG_RST_EN
    .jtag_rst_en_i(1'b0),
`endif
    .bus(bus8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Instruction memory: in-order, fixed latency, optional gaps.
  typedef struct {logic [31:0] a; int t;} mreq_t;
  mreq_t memq[$];
  int    lat = 1;
  bit    gap = 0;
  int    cyc_n = 0;

  // Reference model state.
  typedef struct {logic [31:0] a; bit stale;} fl_t;
  typedef struct {logic [31:0] pc; logic [31:0] d;} iq_t;
  fl_t         infl[$];
  iq_t         iq[$];
  logic [31:0] m_pc;

  logic        jmp, hold, rrdy, irdy;
  logic [31:0] jaddr;

  logic        s_req_v, s_inst_v, s_fire, s_pop;
  logic [31:0] s_req_a, s_inst_pc;

  task automatic cyc();
    bit          rv;
    logic [31:0] rd;
    bit          flush, e_req_v, e_inst_v;
    fl_t         f;
    rv = 0;
    rd = '0;
    if (memq.size() > 0 && cyc_n >= memq[0].t + lat &&
        !(gap && $urandom_range(0, 3) == 0)) begin
      rv = 1;
      rd = memf(memq[0].a);
      memq.delete(0);
    end
    bus.jmp_en_i     = jmp;
    bus.jmp_addr_i   = jaddr;
    bus.hold_i       = hold;
    bus.req_ready_i  = rrdy;
    bus.rsp_valid_i  = rv;
    bus.rsp_data_i   = rd;
    bus.inst_ready_i = irdy;
    @(negedge clk);
    flush    = jmp || jtag;
    e_req_v  = !flush && !hold &&
               (infl.size() + iq.size() < DEPTH);
    e_inst_v = !flush && iq.size() > 0;
    s_req_v   = bus.req_valid_o;
    s_req_a   = bus.req_addr_o;
    s_inst_v  = bus.inst_valid_o;
    s_inst_pc = bus.inst_pc_o;
    chk("req_valid", 32'(s_req_v), 32'(e_req_v));
    chk("req_addr", s_req_a, m_pc);
    chk("inst_valid", 32'(s_inst_v), 32'(e_inst_v));
    if (e_inst_v && s_inst_v) begin
      chk("inst_pc", s_inst_pc, iq[0].pc);
      chk("inst", bus.inst_o, iq[0].d);
    end
    s_fire = s_req_v && rrdy;
    s_pop  = s_inst_v && irdy;
    @(posedge clk);
    if (s_fire) memq.push_back('{a: s_req_a, t: cyc_n});
    if (e_inst_v && irdy) iq.delete(0);
    if (rv && infl.size() > 0) begin
      f = infl[0];
      infl.delete(0);
      if (!f.stale && !flush)
        iq.push_back('{pc: f.a, d: memf(f.a)});
    end
    if (flush) begin
      foreach (infl[i]) infl[i].stale = 1;
      iq.delete();
      m_pc = jtag ? RST_PC : jaddr;
    end else if (e_req_v && rrdy) begin
      infl.push_back('{a: m_pc, stale: 0});
      m_pc = m_pc + STEP;
    end
    cyc_n++;
    #1;
  endtask

  task automatic idle_in();
    jmp = 0; jaddr = '0; hold = 0; rrdy = 1; irdy = 1;
    jtag = 0;
  endtask

  task automatic do_reset();
    idle_in();
    bus.jmp_en_i = 0; bus.jmp_addr_i = '0; bus.hold_i = 0;
    bus.req_ready_i = 0; bus.rsp_valid_i = 0;
    bus.rsp_data_i = '0; bus.inst_ready_i = 0;
    bus8.jmp_en_i = 0; bus8.jmp_addr_i = '0; bus8.hold_i = 0;
    bus8.req_ready_i = 0; bus8.rsp_valid_i = 0;
    bus8.rsp_data_i = '0; bus8.inst_ready_i = 0;
    rst = 1;
    memq.delete(); infl.delete(); iq.delete();
    m_pc = RST_PC;
    gap = 0;
    @(negedge clk);
    chk("rst req_valid", 32'(bus.req_valid_o), 32'd0);
    chk("rst inst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("rst req_addr", bus.req_addr_o, RST_PC);
    chk("rst inst_pc", bus.inst_pc_o, RST_PC);
    @(posedge clk);
    #1;
    rst = 0;
    cyc_n = 0;
  endtask

  typedef struct {
    logic       hold;
    logic       rv;
    logic [7:0] a;
    logic       iv;
    logic [7:0] pc;
  } v8_t;

  initial begin
    v8_t         tbl[7];
    int          nf, np, first_a;
    bit          found, old_seen;
    logic [31:0] pops[$];
    logic        pv;
    logic [7:0]  pa;

    tbl = '{
      '{0, 1, 8'hF8, 0, 8'h00},
      '{0, 1, 8'hFC, 0, 8'h00},
      '{0, 1, 8'h00, 1, 8'hF8},
      '{0, 1, 8'h04, 1, 8'hFC},
      '{0, 1, 8'h08, 1, 8'h00},
      '{1, 0, 8'h0C, 1, 8'h04},
      '{0, 1, 8'h0C, 1, 8'h08}
    };

    // 8-bit address wrap-around, 1-cycle memory.
    do_reset();
    pv = 0;
    pa = '0;
    bus8.req_ready_i  = 1;
    bus8.inst_ready_i = 1;
    for (int k = 0; k < 7; k++) begin
      bus8.hold_i      = tbl[k].hold;
      bus8.rsp_valid_i = pv;
      bus8.rsp_data_i  = {24'h0, pa};
      @(negedge clk);
      chk($sformatf("w8 req_valid %0d", k),
          32'(bus8.req_valid_o), 32'(tbl[k].rv));
      chk($sformatf("w8 req_addr %0d", k),
          32'(bus8.req_addr_o), 32'(tbl[k].a));
      chk($sformatf("w8 inst_valid %0d", k),
          32'(bus8.inst_valid_o), 32'(tbl[k].iv));
      if (tbl[k].iv) begin
        chk($sformatf("w8 inst_pc %0d", k),
            32'(bus8.inst_pc_o), 32'(tbl[k].pc));
        chk($sformatf("w8 inst %0d", k),
            bus8.inst_o, {24'h0, tbl[k].pc});
      end
      pv = bus8.req_valid_o && bus8.req_ready_i;
      pa = bus8.req_addr_o;
      @(posedge clk);
      #1;
    end

    // Streaming with 1-cycle memory.
    do_reset();
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k < 6) chk($sformatf("seq addr %0d", k), s_req_a, 32'(4 * k));
      if (k == 1) chk("seq no bypass", 32'(s_inst_v), 32'd0);
      if (k >= 2) begin
        chk($sformatf("seq inst_v %0d", k), 32'(s_inst_v), 32'd1);
        chk($sformatf("seq pc %0d", k), s_inst_pc, 32'(4 * (k - 2)));
      end
    end

    // Downstream stall fills the queue, then drains.
    do_reset();
    lat = 1;
    irdy = 0;
    nf = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (s_fire) nf++;
    end
    chk("stall issued", 32'(nf), 32'd4);
    chk("stall req_valid", 32'(s_req_v), 32'd0);
    irdy = 1;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) chk("drain head pc", s_inst_pc, 32'h0);
      if (s_fire && s_req_a == 32'h10) found = 1;
    end
    chk("drain 0x10 issued", 32'(found), 32'd1);

    // Jump with three requests in flight.
    do_reset();
    lat = 3;
    for (int k = 0; k < 3; k++) cyc();
    jmp = 1; jaddr = 32'h100;
    cyc();
    chk("jmp req_valid", 32'(s_req_v), 32'd0);
    chk("jmp inst_valid", 32'(s_inst_v), 32'd0);
    jmp = 0;
    pops.delete();
    old_seen = 0;
    for (int k = 0; k < 14; k++) begin
      cyc();
      if (s_pop) begin
        pops.push_back(s_inst_pc);
        if (s_inst_pc < 32'h100) old_seen = 1;
      end
    end
    chk("jmp pops", 32'(pops.size() >= 2), 32'd1);
    if (pops.size() >= 2) begin
      chk("jmp first pc", pops[0], 32'h100);
      chk("jmp second pc", pops[1], 32'h104);
    end
    chk("jmp old stream", 32'(old_seen), 32'd0);

    // Hold with two requests outstanding.
    do_reset();
    lat = 3;
    for (int k = 0; k < 2; k++) cyc();
    hold = 1;
    nf = 0;
    np = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (s_fire) nf++;
      if (s_pop) np++;
    end
    chk("hold no issue", 32'(nf), 32'd0);
    chk("hold drained", 32'(np), 32'd2);
    hold = 0;
    first_a = -1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (s_fire && first_a < 0) first_a = int'(s_req_a);
    end
    chk("hold resume addr", 32'(first_a), 32'h8);
    hold = 1; jmp = 1; jaddr = 32'h300;
    cyc();
    hold = 0; jmp = 0;
    cyc();
    chk("hold+jmp addr", s_req_a, 32'h300);
    chk("hold+jmp valid", 32'(s_req_v), 32'd1);

`ifdef JTAG_RST_EN
    // Soft reset with a simultaneous jump.
    do_reset();
    lat = 3;
    for (int k = 0; k < 4; k++) cyc();
    jtag = 1; jmp = 1; jaddr = 32'h200;
    cyc();
    jtag = 0; jmp = 0;
    pops.delete();
    first_a = -1;
    for (int k = 0; k < 14; k++) begin
      cyc();
      if (s_fire && first_a < 0) first_a = int'(s_req_a);
      if (s_pop) pops.push_back(s_inst_pc);
    end
    chk("jtag restart addr", 32'(first_a), RST_PC);
    chk("jtag pops", 32'(pops.size() >= 3), 32'd1);
    if (pops.size() >= 3) begin
      chk("jtag pc0", pops[0], RST_PC);
      chk("jtag pc1", pops[1], RST_PC + 32'd4);
      chk("jtag pc2", pops[2], RST_PC + 32'd8);
    end
`endif

    // Randomised traffic against the queue model.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      lat = $urandom_range(1, 3);
      gap = 1;
      for (int k = 0; k < 700; k++) begin
        jmp   = ($urandom_range(0, 15) == 0);
        jaddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 :
                ($urandom & ~32'h3);
        hold  = ($urandom_range(0, 4) == 0);
        rrdy  = ($urandom_range(0, 3) != 0);
        irdy  = ($urandom_range(0, 2) != 0);
`ifdef JTAG_RST_EN
        jtag  = ($urandom_range(0, 31) == 0);
`endif
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
